// File: rtl/fetch_pkg.sv
// fetch_pkg: shared states, byte width and byte-count sizing for the instruction fetch controller
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_e;
  localparam int BYTE_W = 8;
  localparam int INST_BYTES_DEF = 3;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int BYTE_CNT_W = cnt_width(INST_BYTES_DEF);
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts consecutive REQ cycles without an ack and flags the final one
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYC = 15,
  localparam int CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  logic [CW-1:0] count_q, count_d;
  assign expired = count_en && !clear && (count_q == CW'(TIMEOUT_CYC - 1));
  always_comb count_d = clear ? '0 : (count_en ? count_q + CW'(1) : count_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: byte-serial instruction fetch FSM owning the PC.
// Define FETCH_TIMEOUT_EN to enable the memory-ack timeout and sticky fetch_err.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_BYTES = INST_BYTES_DEF,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         mem_req,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_ack,
  input  logic [BYTE_W-1:0]            mem_data,
  input  logic                         pc_load,
  input  logic [ADDR_W-1:0]            pc_in,
  output logic [ADDR_W-1:0]            pc,
  output logic [BYTE_W*INST_BYTES-1:0] instr,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic                         busy,
  output logic                         fetch_err
);
  localparam int IW = BYTE_W * INST_BYTES;
  localparam int CW = cnt_width(INST_BYTES);
  state_e          state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   asm_q, asm_d, instr_q, instr_d;
  logic            expired, last;
  assign last        = cnt_q == CW'(INST_BYTES - 1);
  assign mem_req     = state_q == REQ;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = state_q == VALID;
  assign busy        = state_q != IDLE;
`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q != REQ || mem_ack || pc_load),
    .count_en (state_q == REQ),
    .expired  (expired)
  );
  assign fetch_err = state_q == ERR;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign expired   = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    instr_d = instr_q;
    // A reload wins over everything, including an ack arriving in the same cycle
    if (pc_load) begin
      pc_d    = pc_in;
      cnt_d   = '0;
      state_d = enable ? REQ : IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = enable ? REQ : IDLE;
        REQ: begin
          if (mem_ack) begin
            asm_d[BYTE_W*(INST_BYTES-1-int'(cnt_q)) +: BYTE_W] = mem_data;
            pc_d    = pc_q + ADDR_W'(1);
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            instr_d = last ? asm_d : instr_q;
            state_d = last ? VALID : REQ;
          end else if (expired) state_d = ERR;
        end
        VALID: state_d = instr_ready ? (enable ? REQ : IDLE) : VALID;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= ADDR_W'(RESET_PC);
      cnt_q   <= '0;
      asm_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      instr_q <= instr_d;
    end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed and random checks of fetch_controller against a transaction-level model
module tb_fetch_controller;
  localparam int TO = 15;
  logic clk = 0, rst = 1, enable = 0, mem_ack = 0, pc_load = 0, instr_ready = 0;
  logic [7:0] mem_data = 0, pc_in = 0;
  logic mem_req, instr_valid, busy, fetch_err;
  logic [7:0] mem_addr, pc;
  logic [23:0] instr;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem [256];
  bit m_fetch, m_pend, m_err;
  logic [7:0] m_pc;
  logic [23:0] m_instr;
  byte unsigned m_q[$];
  int m_tc;

  fetch_controller dut (
    .clk(clk), .rst(rst), .enable(enable), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .pc_load(pc_load), .pc_in(pc_in), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_fetch = 0; m_pend = 0; m_err = 0; m_pc = 0; m_instr = 0; m_tc = 0;
    m_q.delete();
  endtask

  task automatic m_step();
    if (pc_load) begin
      m_pc = pc_in; m_q.delete(); m_pend = 0; m_err = 0; m_fetch = enable; m_tc = 0;
    end else if (m_err) begin
    end else if (m_pend) begin
      if (instr_ready) begin m_pend = 0; m_fetch = enable; m_tc = 0; end
    end else if (m_fetch) begin
      if (mem_ack) begin
        m_q.push_back(mem[m_pc]);
        m_pc = m_pc + 8'd1;
        m_tc = 0;
        if (m_q.size() == 3) begin
          m_instr = 0;
          foreach (m_q[i]) m_instr = (m_instr << 8) | 24'(m_q[i]);
          m_q.delete(); m_pend = 1; m_fetch = 0;
        end
      end else begin
        m_tc++;
`ifdef FETCH_TIMEOUT_EN
        if (m_tc == TO) begin m_err = 1; m_fetch = 0; end
`endif
      end
    end else if (enable) begin
      m_fetch = 1; m_tc = 0;
    end
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, m_fetch);
    if (m_fetch) chk("mem_addr", mem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("instr_valid", instr_valid, m_pend);
    chk("instr", instr, m_instr);
    chk("busy", busy, m_fetch | m_pend | m_err);
    chk("fetch_err", fetch_err, m_err);
  endtask

  task automatic step();
    mem_data = mem[m_pc];
    m_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int lat;
    logic [23:0] exp_i;
    foreach (mem[i]) mem[i] = 8'($urandom);
    m_reset();
    #1 check_all();
    @(negedge clk) rst = 0;
    // 1: basic fetch and latency
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    enable = 1; mem_ack = 1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (instr_valid && lat == 0) lat = i;
    end
    chk("t1_latency", 24'(lat), 24'd4);
    chk("t1_instr", instr, 24'hA1B2C3);
    chk("t1_pc", pc, 24'h03);
    // 2: stall, then resume at 3, then drop to idle
    for (int i = 0; i < 5; i++) step();
    chk("t2_stable_instr", instr, 24'hA1B2C3);
    chk("t2_stable_req", mem_req, 1'b0);
    instr_ready = 1;
    step();
    chk("t2_next_addr", mem_addr, 24'h03);
    instr_ready = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t2_valid", instr_valid, 1'b1);
    enable = 0; instr_ready = 1;
    step();
    chk("t2_idle_busy", busy, 1'b0);
    // 3: reload with address wrap
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    instr_ready = 0; enable = 1; pc_load = 1; pc_in = 8'hFE;
    step();
    pc_load = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t3_instr", instr, 24'h112233);
    chk("t3_pc", pc, 24'h01);
    // 4: reload mid-instruction discards partial bytes and drops the coincident ack
    instr_ready = 1;
    step();
    instr_ready = 0;
    step(); step();
    pc_load = 1; pc_in = 8'h40;
    step();
    chk("t4_flushed_valid", instr_valid, 1'b0);
    chk("t4_pc", pc, 24'h40);
    pc_load = 0;
    for (int i = 0; i < 10 && !instr_valid; i++) step();
    exp_i = {mem[8'h40], mem[8'h41], mem[8'h42]};
    chk("t4_instr", instr, exp_i);
    // 5: async reset between edges in REQ
    instr_ready = 1;
    step();
    instr_ready = 0; mem_ack = 0;
    step();
    rst = 1;
    #1;
    chk("t5_req", mem_req, 1'b0);
    chk("t5_valid", instr_valid, 1'b0);
    chk("t5_pc", pc, 24'h00);
    m_reset();
    check_all();
    @(negedge clk) rst = 0;
`ifdef FETCH_TIMEOUT_EN
    // 6: timeout then recovery via reload
    enable = 1; mem_ack = 0;
    step();
    for (int i = 0; i < TO; i++) step();
    chk("t6_err", fetch_err, 1'b1);
    chk("t6_req", mem_req, 1'b0);
    pc_load = 1; pc_in = 8'h00;
    step();
    pc_load = 0;
    chk("t6_err_clr", fetch_err, 1'b0);
    chk("t6_addr", mem_addr, 24'h00);
`endif
    // random phase
    for (int i = 0; i < 600; i++) begin
      enable      = $urandom_range(0, 3) != 0;
      mem_ack     = $urandom_range(0, 4) < 3;
      instr_ready = $urandom_range(0, 1) == 1;
      pc_load     = $urandom_range(0, 19) == 0;
      pc_in       = 8'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
